// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and FSM state encoding shared by the alu_seq files.
package alu_pkg;
  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the ALU stage and its requester/accumulator.
interface alu_seq_if #(parameter int DATA_WIDTH = 8, parameter int OP_WIDTH = 3);
  logic start;
  logic [OP_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] acc_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] alu_out;
  logic ld_ac;
  logic zero;
  logic carry;
  logic busy;
  modport master(output start, opcode, acc_in, data_in, input alu_out, ld_ac, zero, carry, busy);
  modport slave(input start, opcode, acc_in, data_in, output alu_out, ld_ac, zero, carry, busy);
endinterface

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative unsigned multiplier, one shift-add step per clock, DATA_WIDTH steps.
module shift_add_mul #(parameter int DATA_WIDTH = 8) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic done
);
  localparam int CW = $clog2(DATA_WIDTH);
  logic [2*DATA_WIDTH-1:0] mcand, acc, acc_nxt;
  logic [DATA_WIDTH-1:0] mplier;
  logic [CW-1:0] cnt;
  logic run;
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  // done and product look one step ahead so the caller can register the result on the final edge
  assign done = run && cnt == CW'(DATA_WIDTH - 1);
  assign product = acc_nxt;
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (load) begin
      run <= 1'b1;
      cnt <= '0;
      acc <= '0;
      mcand <= {{DATA_WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc <= acc_nxt;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      run <= !done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU stage feeding the accumulator (result + one-cycle ld_ac strobe).
// Define ALU_MUL_EN to build the shift-add MUL; otherwise opcode 111 passes A through in one cycle.
module alu_seq import alu_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH = 3
) (
  input logic clk,
  input logic n_rst,
  alu_seq_if.slave bus
);
  localparam int W = DATA_WIDTH;
  state_t state, state_nxt;
  logic accept, wr, mul_go, mul_done;
  logic [2*W-1:0] product;
  logic [W:0] res, res_d;
  logic [W-1:0] a, b, alu_out;
  logic zero, carry;
  assign a = bus.acc_in;
  assign b = bus.data_in;
  assign accept = bus.start && state != ST_MUL;
`ifdef ALU_MUL_EN
  assign mul_go = accept && bus.opcode == OP_MUL;
  shift_add_mul #(.DATA_WIDTH(W)) u_mul (
    .clk(clk), .n_rst(n_rst), .load(mul_go), .a(a), .b(b), .product(product), .done(mul_done)
  );
  assign bus.busy = state == ST_MUL;
`else
  assign mul_go = 1'b0;
  assign mul_done = 1'b0;
  assign product = '0;
  assign bus.busy = 1'b0;
`endif
  // bit W of res carries the carry/borrow flag of the single-cycle ops
  always_comb begin
    res = {1'b0, b};
    case (bus.opcode)
      OP_ADD: res = {1'b0, a} + {1'b0, b};
      OP_SUB: res = {1'b0, a} - {1'b0, b};
      OP_AND: res = {1'b0, a & b};
      OP_XOR: res = {1'b0, a ^ b};
      OP_SHL: res = {a, 1'b0};
      OP_SHR: res = {a[0], 1'b0, a[W-1:1]};
      OP_MUL: res = {1'b0, a};
      default: ;
    endcase
  end
  assign res_d = mul_done ? {|product[2*W-1:W], product[W-1:0]} : res;
  assign wr = (accept && !mul_go) || mul_done;
  always_comb begin
    state_nxt = state == ST_DONE ? ST_IDLE : state;
    if (accept) state_nxt = mul_go ? ST_MUL : ST_DONE;
    else if (mul_done) state_nxt = ST_DONE;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= ST_IDLE;
      alu_out <= '0;
      zero <= 1'b0;
      carry <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr) begin
        alu_out <= res_d[W-1:0];
        zero <= res_d[W-1:0] == '0;
        carry <= res_d[W];
      end
    end
  end
  assign bus.alu_out = alu_out;
  assign bus.zero = zero;
  assign bus.carry = carry;
  assign bus.ld_ac = state == ST_DONE;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;
  localparam int MOD = 1 << W;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_out = '0;
  logic exp_z = 1'b0;
  logic exp_c = 1'b0;
  alu_seq_if #(.DATA_WIDTH(W), .OP_WIDTH(3)) bus ();
  alu_seq #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // returns {carry, result}
  function automatic logic [W:0] model(input logic [2:0] op, input int a, input int b);
    int r;
    bit c;
    c = 0;
    r = 0;
    case (op)
      3'd0: r = b;
      3'd1: begin r = a + b; c = r >= MOD; end
      3'd2: begin r = a - b; c = a < b; end
      3'd3: r = a & b;
      3'd4: r = a ^ b;
      3'd5: begin r = a * 2; c = a >= MOD / 2; end
      3'd6: begin r = a / 2; c = (a % 2) == 1; end
      default: begin
`ifdef ALU_MUL_EN
        r = a * b;
        c = r >= MOD;
`else
        r = a;
`endif
      end
    endcase
    r = ((r % MOD) + MOD) % MOD;
    return {c, r[W-1:0]};
  endfunction
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] m;
    bit mul;
    m = model(op, a, b);
    mul = 0;
`ifdef ALU_MUL_EN
    mul = op == 3'd7;
`endif
    bus.start = 1'b1;
    bus.opcode = op;
    bus.acc_in = a;
    bus.data_in = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.opcode = 3'($urandom);
    bus.acc_in = W'($urandom);
    bus.data_in = W'($urandom);
    if (mul) begin
      for (int i = 0; i < W; i++) begin
        check("mul_busy", bus.busy, 1);
        check("mul_no_ld", bus.ld_ac, 0);
        check("mul_hold", bus.alu_out, exp_out);
        bus.start = 1'($urandom);
        @(posedge clk); #1;
      end
      bus.start = 1'b0;
    end
    exp_out = m[W-1:0];
    exp_z = exp_out == 0;
    exp_c = m[W];
    check("ld_ac", bus.ld_ac, 1);
    check("busy_done", bus.busy, 0);
    check("alu_out", bus.alu_out, exp_out);
    check("zero", bus.zero, exp_z);
    check("carry", bus.carry, exp_c);
  endtask
  task automatic idle();
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("idle_ld", bus.ld_ac, 0);
    check("idle_hold", bus.alu_out, exp_out);
    check("idle_busy", bus.busy, 0);
  endtask
  task automatic check_reset_outputs();
    check("rst_out", bus.alu_out, 0);
    check("rst_ld", bus.ld_ac, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_busy", bus.busy, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.opcode = '0;
    bus.acc_in = '0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    n_rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();
    do_op(3'd1, 8'hF0, 8'h20);
    idle();
    do_op(3'd2, 8'h05, 8'h05);
    idle();
    do_op(3'd2, 8'h03, 8'h05);
    idle();
`ifdef ALU_MUL_EN
    do_op(3'd7, 8'h0C, 8'h0B);
    idle();
    do_op(3'd7, 8'h20, 8'h10);
    idle();
`else
    do_op(3'd7, 8'h5A, 8'hC3);
    idle();
`endif
    do_op(3'd0, 8'h99, 8'h33);
    do_op(3'd4, 8'h33, 8'h0F);
    idle();
    bus.start = 1'b1;
    bus.opcode = 3'd7;
    bus.acc_in = 8'h0C;
    bus.data_in = 8'h0B;
    @(posedge clk); #1;
    bus.start = 1'b0;
`ifdef ALU_MUL_EN
    repeat (3) @(posedge clk);
    #1;
`endif
    n_rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();
    n_rst = 1'b1;
    exp_out = '0;
    exp_z = 1'b0;
    exp_c = 1'b0;
    for (int i = 0; i < W + 2; i++) idle();
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom), W'($urandom), W'($urandom));
      if ($urandom_range(1, 0) == 1) idle();
    end
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
